// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: assembles channel-voice messages with running status,
// realtime passthrough, system-message resync and optional channel filtering.
package MIDI;
  localparam int CHANNEL_WIDTH = 4;

  typedef enum logic {
    DATA   = 1'b0,
    STATUS = 1'b1
  } byte_type_t;

  typedef struct packed {
    logic [3:0] message_type;
    logic [6:0] data_byte1;
    logic [6:0] data_byte2;
  } message_t;
endpackage

module midi_message_parser #(
  parameter bit                             FILTER_EN = 1'b0,
  parameter logic [MIDI::CHANNEL_WIDTH-1:0] LISTEN_CH = 4'd0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             byte_valid,
  input  logic [7:0]                       byte_data,
  output logic                             message_valid,
  output MIDI::message_t                   message,
  output logic [MIDI::CHANNEL_WIDTH-1:0]   channel,
  output logic [7:0]                       dropped_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } state_t;

  state_t     state;
  logic [7:0] run_status;
  logic [6:0] data1;
  // Set from a status byte or first data byte until the message completes.
  logic       pending;

  logic [3:0] run_type;
  logic       passes;
  logic       emit;
  logic       is_status;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic needs_two(input logic [3:0] t);
    return !(t == 4'hC || t == 4'hD);
  endfunction

  assign is_status = (MIDI::byte_type_t'(byte_data[7]) == MIDI::STATUS);
  assign run_type  = run_status[7:4];
  assign passes    = !FILTER_EN || (run_status[3:0] == LISTEN_CH);
  assign emit      = passes && (run_type inside {4'h8, 4'h9, 4'hB, 4'hC});

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      run_status    <= 8'h00;
      pending       <= 1'b0;
      message_valid <= 1'b0;
      message       <= '0;
      channel       <= '0;
      dropped_count <= 8'h00;
    end else begin
      message_valid <= 1'b0;
      if (byte_valid) begin
        if (is_status) begin
          if (byte_data[7:3] == 5'b11111) begin
            // Realtime bytes may land anywhere and must not disturb parsing.
          end else if (byte_data[7:4] == 4'hF) begin
            state      <= IDLE;
            run_status <= 8'h00;
            pending    <= 1'b0;
          end else begin
            if (pending) dropped_count <= sat_inc(dropped_count);
            run_status <= byte_data;
            pending    <= 1'b1;
            state      <= WAIT_D1;
          end
        end else begin
          case (state)
            IDLE: dropped_count <= sat_inc(dropped_count);
            WAIT_D1: begin
              data1 <= byte_data[6:0];
              if (needs_two(run_type)) begin
                state   <= WAIT_D2;
                pending <= 1'b1;
              end else begin
                state   <= WAIT_D1;
                pending <= 1'b0;
                if (emit) begin
                  message_valid <= 1'b1;
                  message       <= '{message_type: run_type,
                                     data_byte1:   byte_data[6:0],
                                     data_byte2:   7'd0};
                  channel       <= run_status[3:0];
                end
              end
            end
            WAIT_D2: begin
              state   <= WAIT_D1;
              pending <= 1'b0;
              if (emit) begin
                message_valid <= 1'b1;
                message       <= '{message_type: run_type,
                                   data_byte1:   data1,
                                   data_byte2:   byte_data[6:0]};
                channel       <= run_status[3:0];
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Scoreboard bench: an unfiltered parser and a channel-1 filtered parser share one byte stream.
module tb_midi_message_parser;

  logic           clk = 1'b0;
  logic           reset;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           mv0, mv1;
  MIDI::message_t msg0, msg1;
  logic [3:0]     ch0, ch1;
  logic [7:0]     drop0, drop1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [17:0] msg;
    logic [3:0]  ch;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_message_parser dut (
    .clock(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .message_valid(mv0), .message(msg0), .channel(ch0), .dropped_count(drop0)
  );

  midi_message_parser #(.FILTER_EN(1'b1), .LISTEN_CH(4'd1)) dut_f (
    .clock(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .message_valid(mv1), .message(msg1), .channel(ch1), .dropped_count(drop1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected message becomes visible one cycle after the byte driven now.
  task automatic exp_msg(input logic [3:0] t, input logic [6:0] a, input logic [6:0] b,
                         input logic [3:0] ch);
    exp_t e;
    e.msg = {t, a, b};
    e.ch  = ch;
    e.cyc = cyc + 1;
    q0.push_back(e);
    if (ch == 4'd1) q1.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle(3);
    check({tag, "_q0_empty"}, 32'(q0.size()), 32'd0);
    check({tag, "_q1_empty"}, 32'(q1.size()), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mv0 === 1'b1) begin
      if (q0.size() == 0) check("unexpected_strobe0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("msg0", 32'(msg0), 32'(e.msg));
        check("ch0", 32'(ch0), 32'(e.ch));
        check("latency0", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mv1 === 1'b1) begin
      if (q1.size() == 0) check("unexpected_strobe1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("msg1", 32'(msg1), 32'(e.msg));
        check("ch1", 32'(ch1), 32'(e.ch));
        check("latency1", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    check("rst_valid", 32'(mv0), 32'd0);
    check("rst_msg", 32'(msg0), 32'd0);
    check("rst_ch", 32'(ch0), 32'd0);
    check("rst_drop", 32'(drop0), 32'd0);

    // Single note-on
    send(8'h90); send(8'h3C); exp_msg(4'h9, 7'h3C, 7'h64, 4'h0); send(8'h64);
    drain("t1");

    // Running status
    send(8'h93); send(8'h40); exp_msg(4'h9, 7'h40, 7'h10, 4'h3); send(8'h10);
    send(8'h41); exp_msg(4'h9, 7'h41, 7'h00, 4'h3); send(8'h00);
    drain("t2");

    // Realtime clock byte inside a control change
    send(8'hB0); send(8'h15); send(8'hF8); exp_msg(4'hB, 7'h15, 7'h7F, 4'h0); send(8'h7F);
    drain("t3");
    check("t3_drop", 32'(drop0), 32'd0);

    // Program change, silent pitch bend, SysEx payload plus stray data
    send(8'hC2); exp_msg(4'hC, 7'h05, 7'h00, 4'h2); send(8'h05);
    send(8'hE0); send(8'h00); send(8'h40);
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h10);
    drain("t4");
    check("t4_drop", 32'(drop0), 32'd3);
    check("t4_drop_f", 32'(drop1), 32'd3);

    // Channel filter: channel 0 reaches only the unfiltered parser
    send(8'h90); send(8'h3C); exp_msg(4'h9, 7'h3C, 7'h64, 4'h0); send(8'h64);
    send(8'h91); send(8'h3C); exp_msg(4'h9, 7'h3C, 7'h64, 4'h1); send(8'h64);
    drain("t5");
    check("t5_drop_f", 32'(drop1), 32'd3);

    // Reset mid-message, with a byte strobed in the reset cycle
    send(8'h90); send(8'h3C);
    reset = 1'b1; byte_valid = 1'b1; byte_data = 8'h64;
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    check("t6_rst_drop", 32'(drop0), 32'd0);
    check("t6_rst_valid", 32'(mv0), 32'd0);
    check("t6_rst_msg", 32'(msg0), 32'd0);
    send(8'h64);
    drain("t6a");
    check("t6_drop1", 32'(drop0), 32'd1);

    for (int i = 0; i < 300; i++) send(8'(i % 128));
    check("t6_sat", 32'(drop0), 32'hFF);
    check("t6_sat_f", 32'(drop1), 32'hFF);
    send(8'h05);
    check("t6_sat_hold", 32'(drop0), 32'hFF);

    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'h80); send(8'h3C); send(8'h90);
    drain("t6b");
    check("t6_abort_drop", 32'(drop0), 32'd1);
    // The interrupting note-on still works as a fresh message
    send(8'h3D); exp_msg(4'h9, 7'h3D, 7'h22, 4'h0); send(8'h22);
    drain("t6c");
    check("t6_final_drop", 32'(drop0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
